// File: rtl/ldpc_pkg.sv
// Shared types for the LDPC encoder datapath: row-accumulator FSM states and default sub-block width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ldpc_pkg;

    localparam int MAXZ_DEFAULT = 81;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/ldpc_row_accumulator.sv
// XORs the rotated sub-blocks of one base-matrix row into a single parity sub-block.
// Latency: result valid 1 clock after the last beat of the row; back-to-back rows need no bubble.
// Backpressure: result held in HOLD until out_ready; beats or starts arriving when they cannot be used are dropped and flagged on drop_err.
module ldpc_row_accumulator
    import ldpc_pkg::*;
#(
    parameter int MAXZ      = MAXZ_DEFAULT,
    parameter int MAX_TERMS = 24,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   num_terms,
    input  logic            valid_in,
    input  logic [MAXZ-1:0] in_data,
    input  logic            out_ready,
    output logic [MAXZ-1:0] out_data,
    output logic            valid_out,
    output logic            busy,
    output logic            drop_err
);

    state_t          state_q, state_d;
    logic [MAXZ-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   tgt_q, tgt_d;
    logic [MAXZ-1:0] out_data_q, out_data_d;
    logic            valid_out_q, valid_out_d;
    logic            drop_err_q, drop_err_d;

    logic            start_ok;
    logic            hs;
    logic            launch;
    logic [CW-1:0]   cnt_inc;
    logic [MAXZ-1:0] acc_next;

    // cnt stays below tgt while accumulating, so cnt_inc never exceeds MAX_TERMS and fits in CW bits.
    assign start_ok = (num_terms != '0) && (num_terms <= CW'(MAX_TERMS));
    assign hs       = valid_out_q && out_ready;
    assign launch   = start && start_ok && ((state_q == IDLE) || ((state_q == HOLD) && hs));
    assign cnt_inc  = cnt_q + CW'(1);
    assign acc_next = acc_q ^ in_data;

    // Next-state logic: per-state accumulate/hold/drop handling, then a shared row-launch override.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        out_data_d  = out_data_q;
        valid_out_d = valid_out_q;
        drop_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !start_ok) begin
                    drop_err_d = 1'b1;
                end else if (valid_in && !start) begin
                    drop_err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    drop_err_d = 1'b1;
                end
                if (valid_in) begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == tgt_q) begin
                        state_d     = HOLD;
                        out_data_d  = acc_next;
                        valid_out_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!hs) begin
                    if (start || valid_in) begin
                        drop_err_d = 1'b1;
                    end
                end else begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    valid_out_d = 1'b0;
                    if (start && !start_ok) begin
                        drop_err_d = 1'b1;
                    end else if (valid_in && !start) begin
                        drop_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A beat presented with start counts as term 1; a one-term row goes straight to HOLD.
        if (launch) begin
            tgt_d       = num_terms;
            valid_out_d = 1'b0;
            if (valid_in) begin
                acc_d = in_data;
                cnt_d = CW'(1);
                if (num_terms == CW'(1)) begin
                    state_d     = HOLD;
                    out_data_d  = in_data;
                    valid_out_d = 1'b1;
                end else begin
                    state_d = ACCUM;
                end
            end else begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ACCUM;
            end
        end
    end

    // State and datapath registers with synchronous reset that discards any row in flight.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tgt_q       <= '0;
            out_data_q  <= '0;
            valid_out_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            out_data_q  <= out_data_d;
            valid_out_q <= valid_out_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign valid_out = valid_out_q;
    assign busy      = (state_q != IDLE);
    assign drop_err  = drop_err_q;

endmodule

// File: doc/ldpc_row_accumulator.md
LDPC_ROW_ACCUMULATOR -- requirements
Module: ldpc_row_accumulator

Interface
REQ-001 SHALL have parameter MAXZ, default 81, giving the rotated sub-block width in bits.
REQ-002 SHALL have parameter MAX_TERMS, default 24, giving the maximum number of sub-blocks XORed per base-matrix row.
REQ-003 SHALL derive localparam CW = $clog2(MAX_TERMS+1) as the term-count width.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a row; num_terms is sampled in the same cycle.
REQ-007 SHALL have port num_terms, input, CW bits: number of sub-blocks in this row (1..MAX_TERMS).
REQ-008 SHALL have port valid_in, input, 1 bit: in_data holds a rotated sub-block from the upstream rotator.
REQ-009 SHALL have port in_data, input, MAXZ bits: rotated sub-block.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 SHALL have port out_data, output, MAXZ bits: XOR of all sub-blocks of the row.
REQ-012 SHALL have port valid_out, output, 1 bit: out_data is valid and held until accepted.
REQ-013 SHALL have port busy, output, 1 bit: high in ACCUM or HOLD.
REQ-014 SHALL have port drop_err, output, 1 bit: one-cycle pulse when a beat or start is discarded.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and HOLD, with a MAXZ-bit accumulator acc and a CW-bit counter cnt.
REQ-016 IDLE: start with num_terms in 1..MAX_TERMS SHALL latch num_terms into tgt, clear acc and cnt, and go to ACCUM.
REQ-017 IDLE: start with num_terms==0 or num_terms>MAX_TERMS SHALL be ignored, stay in IDLE, and pulse drop_err.
REQ-018 IDLE: start and valid_in in the same cycle SHALL count in_data as term 1 (acc<=in_data, cnt<=1); if tgt==1, SHALL go directly to HOLD.
REQ-019 ACCUM: each valid_in cycle SHALL update acc<=acc^in_data and cnt<=cnt+1; cycles without valid_in SHALL leave state unchanged.
REQ-020 ACCUM: the beat that makes cnt equal tgt SHALL move to HOLD with out_data=acc^in_data registered; valid_out SHALL be high in the next cycle (latency 1 clock after the last beat).
REQ-021 HOLD: valid_out SHALL stay high and out_data SHALL stay stable until out_ready; the handshake completes in the cycle where valid_out and out_ready are both high.
REQ-022 HOLD, handshake without start: SHALL go to IDLE with acc cleared, and valid_out SHALL go low next cycle.
REQ-023 HOLD, handshake with start in the same cycle: SHALL behave as REQ-016/REQ-018 (back-to-back rows, no idle bubble).
REQ-024 valid_in in IDLE without start, or in HOLD without the REQ-023 case, SHALL be discarded and pulse drop_err.
REQ-025 start while in ACCUM, or in HOLD without a handshake, SHALL be ignored and pulse drop_err; tgt SHALL be unchanged.
REQ-026 drop_err SHALL be registered: high exactly one cycle, in the cycle after the offending input.
REQ-027 cnt SHALL never exceed tgt, and no arithmetic SHALL wrap.

Reset
REQ-028 rst high at any clock edge SHALL force state IDLE, acc=0, cnt=0, tgt=0, out_data=0, valid_out=0, busy=0, drop_err=0.
REQ-029 rst mid-row (ACCUM or HOLD) SHALL discard the partial or pending result with no output produced.
REQ-030 All other inputs SHALL be ignored in any cycle where rst is high.

Structure
REQ-031 The state enum (IDLE/ACCUM/HOLD) and the MAXZ default SHALL live in shared package ldpc_pkg.
REQ-032 SHALL be a single module with no sub-module; the counter and FSM stay inline.

Verification
REQ-033 num_terms=3 with beats 81'h1, 81'h2, 81'h4 on consecutive cycles -> valid_out 1 cycle after the third beat, out_data=81'h7.
REQ-034 num_terms=2 with beats 81'hF0 and 81'hFF separated by 3 idle cycles, out_ready low for 4 cycles -> out_data=81'h0F held stable, valid_out high until out_ready.
REQ-035 start+valid_in with num_terms=1 and in_data=81'hA5 -> valid_out next cycle, out_data=81'hA5; handshake with start and num_terms=2 in the same cycle -> busy stays high and the next row accumulates correctly.
REQ-036 valid_in in IDLE, start in ACCUM, and start with num_terms=0 -> drop_err pulses once for each, and acc and tgt are unaffected.
REQ-037 rst asserted after 2 of 4 beats -> all outputs zero next cycle; a fresh row of 4 beats then yields only its own XOR.
